// File: rtl/sqrt_pkg.sv
// sqrt_pkg
//   Shared constants, FSM state encodings and the result record used by the
//   sqrt result collector, its interface and its output FIFO.
package sqrt_pkg;

    localparam int WD_W       = 6;              // one serial result word
    localparam int NWORDS     = 6;              // words per result, MSB word first
    localparam int ROOT_W     = 32;             // assembled root width
    localparam int SR_W       = NWORDS * WD_W;  // full frame width (36)
    localparam int HIST_W     = SR_W - WD_W;    // bits kept between words (30)
    localparam int FIFO_DEPTH = 2;              // output FIFO entries (power of 2)
    localparam int TMO_CYCLES = 16;             // max idle cycles inside a frame

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    typedef struct packed {
        logic              range_err;
        logic [ROOT_W-1:0] root;
    } sqrt_result_t;

endpackage

// File: rtl/sqrt_result_collect_if.sv
// sqrt_result_collect_if
//   Bundles the serial word stream from the sqrt core, the root valid/ready
//   handshake towards the next stage and the error/status outputs.
//   slave  : collector side (consumes words, produces roots and status)
//   master : environment side (produces words, consumes roots and status)
interface sqrt_result_collect_if;
    import sqrt_pkg::*;

    logic              sqrt_en;
    logic [WD_W-1:0]   sqrt_t_wd;
    logic [WD_W-1:0]   sqrt_st;
    logic [ROOT_W-1:0] root_o;
    logic              range_err_o;
    logic              root_vld_o;
    logic              root_rdy_i;
    logic              frame_err_o;
    logic              tmo_err_o;
    logic              ovf_o;
    logic [7:0]        drop_cnt_o;

    modport slave (
        input  sqrt_en, sqrt_t_wd, sqrt_st, root_rdy_i,
        output root_o, range_err_o, root_vld_o,
        output frame_err_o, tmo_err_o, ovf_o, drop_cnt_o
    );

    modport master (
        output sqrt_en, sqrt_t_wd, sqrt_st, root_rdy_i,
        input  root_o, range_err_o, root_vld_o,
        input  frame_err_o, tmo_err_o, ovf_o, drop_cnt_o
    );

endinterface

// File: rtl/sqrt_res_fifo.sv
// sqrt_res_fifo
//   Small synchronous show-ahead FIFO of assembled results.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     push       write push_data (ignored when full unless popping same cycle)
//     push_data  result to store
//     rdy        consumer ready; head is popped when !empty & rdy
//     head       oldest entry, straight from storage flops
//     empty      no entries (head invalid)
//     full       DEPTH entries held
module sqrt_res_fifo
    import sqrt_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  sqrt_result_t push_data,
    input  logic         rdy,
    output sqrt_result_t head,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);

    sqrt_result_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          wr_en;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign pop   = !empty && rdy;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // accepted when the head is leaving.
    assign wr_en = push && (!full || pop);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sqrt_result_collect.sv
// sqrt_result_collect
//   Collects NWORDS serial result words from the sqrt core into a root,
//   checks word framing and inter-word timeout, flags roots whose discarded
//   upper bits were nonzero, and queues results for a valid/ready consumer.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     bus        sqrt_result_collect_if.slave: word stream in, root handshake
//                out, 1-cycle error pulses and saturating drop counter out
module sqrt_result_collect
    import sqrt_pkg::*;
#(
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int TIMEOUT = TMO_CYCLES
) (
    input logic                  clk,
    input logic                  rst,
    sqrt_result_collect_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT);

    logic [0:0]        state, state_nxt;
    logic [HIST_W-1:0] sr, sr_nxt;
    logic [WD_W-1:0]   widx, widx_nxt;
    logic [TMO_W-1:0]  tmo, tmo_nxt;
    logic [SR_W-1:0]   sr_shift;
    logic [HIST_W-1:0] sr_load;
    logic              frame_err_now;
    logic              tmo_err_now;
    logic              ovf_now;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              frame_err_q;
    logic              tmo_err_q;
    logic              ovf_q;
    logic [7:0]        drop_cnt;
    sqrt_result_t      push_data;
    sqrt_result_t      head;

    // Only HIST_W bits of history are kept; the final word completes the
    // full SR_W-bit frame combinationally, so the push needs no extra cycle.
    assign sr_shift  = {sr, bus.sqrt_t_wd};
    assign sr_load   = {{(HIST_W-WD_W){1'b0}}, bus.sqrt_t_wd};
    assign push_data = {|sr_shift[SR_W-1:ROOT_W], sr_shift[ROOT_W-1:0]};

    always_comb begin
        state_nxt     = state;
        sr_nxt        = sr;
        widx_nxt      = widx;
        tmo_nxt       = tmo;
        frame_err_now = 1'b0;
        tmo_err_now   = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sqrt_en) begin
                    if (bus.sqrt_st == '0) begin
                        sr_nxt    = sr_load;
                        widx_nxt  = WD_W'(1);
                        tmo_nxt   = '0;
                        state_nxt = COLLECT;
                    end else begin
                        frame_err_now = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.sqrt_en) begin
                    tmo_nxt = '0;
                    // widx is never 0 here, so an index-0 word is a restart.
                    if (bus.sqrt_st == widx) begin
                        sr_nxt = sr_shift[HIST_W-1:0];
                        if (widx == WD_W'(NWORDS-1)) begin
                            push      = 1'b1;
                            widx_nxt  = '0;
                            state_nxt = IDLE;
                        end else begin
                            widx_nxt = widx + WD_W'(1);
                        end
                    end else if (bus.sqrt_st == '0) begin
                        frame_err_now = 1'b1;
                        sr_nxt        = sr_load;
                        widx_nxt      = WD_W'(1);
                    end else begin
                        frame_err_now = 1'b1;
                        widx_nxt      = '0;
                        state_nxt     = IDLE;
                    end
                end else if (tmo == TMO_W'(TIMEOUT-1)) begin
                    tmo_err_now = 1'b1;
                    tmo_nxt     = '0;
                    widx_nxt    = '0;
                    state_nxt   = IDLE;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop     = !fifo_empty && bus.root_rdy_i;
    assign ovf_now = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            widx        <= '0;
            tmo         <= '0;
            frame_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            widx        <= widx_nxt;
            tmo         <= tmo_nxt;
            frame_err_q <= frame_err_now;
            tmo_err_q   <= tmo_err_now;
            ovf_q       <= ovf_now;
            // Several drop causes in one cycle still count as one drop.
            if ((frame_err_now || tmo_err_now || ovf_now) && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    sqrt_res_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .rdy      (bus.root_rdy_i),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.root_o      = head.root;
    assign bus.range_err_o = head.range_err;
    assign bus.root_vld_o  = !fifo_empty;
    assign bus.frame_err_o = frame_err_q;
    assign bus.tmo_err_o   = tmo_err_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_sqrt_result_collect.sv
// tb_sqrt_result_collect
//   Directed bench for sqrt_result_collect. Inputs change 1 time unit after
//   a rising edge; outputs are sampled at the same point, i.e. they show the
//   registered state produced by the edge that just passed.
module tb_sqrt_result_collect;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_drop;

    sqrt_result_collect_if bus ();

    sqrt_result_collect dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input logic [5:0] wd, input logic [5:0] idx);
        bus.sqrt_en   = 1'b1;
        bus.sqrt_t_wd = wd;
        bus.sqrt_st   = idx;
        @(posedge clk);
        #1;
        bus.sqrt_en   = 1'b0;
    endtask

    // words holds the whole frame, first (MSB) word in bits 35:30
    task automatic drive_frame(input logic [35:0] words);
        for (int i = 0; i < 6; i++) begin
            drive_word(words[35-6*i -: 6], 6'(i));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++;
        if (bus.root_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_root: got %0h expected 0", bus.root_o);
        end
        checks++;
        if ({bus.root_vld_o, bus.range_err_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_vld_range: got %b expected 00", {bus.root_vld_o, bus.range_err_o});
        end
        checks++;
        if ({bus.frame_err_o, bus.tmo_err_o, bus.ovf_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_pulses: got %b expected 000", {bus.frame_err_o, bus.tmo_err_o, bus.ovf_o});
        end
        checks++;
        if (bus.drop_cnt_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_drop: got %0d expected 0", bus.drop_cnt_o);
        end
        rst = 1'b0;
        idle(1);
        checks++;
        if (bus.root_vld_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_vld: got %b expected 0", bus.root_vld_o);
        end
    endtask

    task automatic test_basic_root;
        bus.root_rdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_word((i == 0) ? 6'h01 : 6'h3F, 6'(i));
        end
        checks++;
        if (bus.root_vld_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_early_vld: got %b expected 0", bus.root_vld_o);
        end
        drive_word(6'h3F, 6'd5);
        checks++;
        if (bus.root_vld_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_vld: got %b expected 1", bus.root_vld_o);
        end
        checks++;
        if (bus.root_o !== 32'h7FFF_FFFF) begin
            failures++;
            $display("[TB] FAIL basic_root: got %0h expected 7fffffff", bus.root_o);
        end
        checks++;
        if (bus.range_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_range: got %b expected 0", bus.range_err_o);
        end
        idle(1);
        checks++;
        if (bus.root_vld_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_popped: got %b expected 0", bus.root_vld_o);
        end
    endtask

    task automatic test_range;
        drive_frame(36'h0_0000_0008);
        checks++;
        if (bus.root_o !== 32'h0000_0008 || bus.range_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL range_small: got root=%0h rerr=%b expected root=8 rerr=0", bus.root_o, bus.range_err_o);
        end
        idle(1);
        drive_frame(36'h4_0000_0000);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.range_err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL range_err: got vld=%b rerr=%b expected vld=1 rerr=1", bus.root_vld_o, bus.range_err_o);
        end
        checks++;
        if (bus.root_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL range_root: got %0h expected 0", bus.root_o);
        end
        idle(1);
    endtask

    task automatic test_frame_err;
        drive_word(6'h00, 6'd0);
        drive_word(6'h00, 6'd1);
        drive_word(6'h00, 6'd3);
        exp_drop++;
        checks++;
        if (bus.frame_err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame_err_pulse: got %b expected 1", bus.frame_err_o);
        end
        checks++;
        if (bus.drop_cnt_o !== 8'(exp_drop)) begin
            failures++;
            $display("[TB] FAIL frame_err_drop: got %0d expected %0d", bus.drop_cnt_o, exp_drop);
        end
        idle(1);
        checks++;
        if ({bus.frame_err_o, bus.root_vld_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL frame_err_clear: got err,vld=%b expected 00", {bus.frame_err_o, bus.root_vld_o});
        end
        // nonzero index while idle
        drive_word(6'h05, 6'd2);
        exp_drop++;
        checks++;
        if (bus.frame_err_o !== 1'b1 || bus.drop_cnt_o !== 8'(exp_drop)) begin
            failures++;
            $display("[TB] FAIL idle_bad_idx: got err=%b drop=%0d expected err=1 drop=%0d", bus.frame_err_o, bus.drop_cnt_o, exp_drop);
        end
        drive_frame(36'h0_0000_0019);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h19 || bus.frame_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_recover: got vld=%b root=%0h err=%b expected vld=1 root=19 err=0", bus.root_vld_o, bus.root_o, bus.frame_err_o);
        end
        idle(1);
        // index 0 mid-frame restarts the frame with that word
        drive_word(6'h3F, 6'd0);
        drive_word(6'h3F, 6'd1);
        drive_word(6'h00, 6'd0);
        exp_drop++;
        checks++;
        if (bus.frame_err_o !== 1'b1 || bus.drop_cnt_o !== 8'(exp_drop)) begin
            failures++;
            $display("[TB] FAIL restart_err: got err=%b drop=%0d expected err=1 drop=%0d", bus.frame_err_o, bus.drop_cnt_o, exp_drop);
        end
        for (int i = 1; i < 5; i++) begin
            drive_word(6'h00, 6'(i));
        end
        drive_word(6'h07, 6'd5);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h7) begin
            failures++;
            $display("[TB] FAIL restart_root: got vld=%b root=%0h expected vld=1 root=7", bus.root_vld_o, bus.root_o);
        end
        idle(1);
    endtask

    task automatic test_timeout;
        drive_word(6'h00, 6'd0);
        drive_word(6'h00, 6'd1);
        idle(15);
        checks++;
        if (bus.tmo_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_early: got %b expected 0", bus.tmo_err_o);
        end
        idle(1);
        exp_drop++;
        checks++;
        if (bus.tmo_err_o !== 1'b1 || bus.drop_cnt_o !== 8'(exp_drop)) begin
            failures++;
            $display("[TB] FAIL tmo_pulse: got tmo=%b drop=%0d expected tmo=1 drop=%0d", bus.tmo_err_o, bus.drop_cnt_o, exp_drop);
        end
        idle(1);
        checks++;
        if (bus.tmo_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_clear: got %b expected 0", bus.tmo_err_o);
        end
        drive_word(6'h01, 6'd0);
        drive_word(6'h02, 6'd1);
        idle(15);
        drive_word(6'h03, 6'd2);
        drive_word(6'h04, 6'd3);
        drive_word(6'h05, 6'd4);
        drive_word(6'h06, 6'd5);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h420C_4146) begin
            failures++;
            $display("[TB] FAIL gap15_root: got vld=%b root=%0h expected vld=1 root=420c4146", bus.root_vld_o, bus.root_o);
        end
        checks++;
        if (bus.drop_cnt_o !== 8'(exp_drop) || bus.tmo_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gap15_no_tmo: got tmo=%b drop=%0d expected tmo=0 drop=%0d", bus.tmo_err_o, bus.drop_cnt_o, exp_drop);
        end
        idle(1);
    endtask

    task automatic test_overflow;
        bus.root_rdy_i = 1'b0;
        drive_frame(36'h1);
        drive_frame(36'h2);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h1 || bus.ovf_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_hold: got vld=%b root=%0h ovf=%b expected vld=1 root=1 ovf=0", bus.root_vld_o, bus.root_o, bus.ovf_o);
        end
        drive_frame(36'h3);
        exp_drop++;
        checks++;
        if (bus.ovf_o !== 1'b1 || bus.drop_cnt_o !== 8'(exp_drop)) begin
            failures++;
            $display("[TB] FAIL ovf_pulse: got ovf=%b drop=%0d expected ovf=1 drop=%0d", bus.ovf_o, bus.drop_cnt_o, exp_drop);
        end
        idle(1);
        checks++;
        if (bus.ovf_o !== 1'b0 || bus.root_o !== 32'h1) begin
            failures++;
            $display("[TB] FAIL ovf_after: got ovf=%b root=%0h expected ovf=0 root=1", bus.ovf_o, bus.root_o);
        end
        bus.root_rdy_i = 1'b1;
        idle(1);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h2) begin
            failures++;
            $display("[TB] FAIL ovf_second: got vld=%b root=%0h expected vld=1 root=2", bus.root_vld_o, bus.root_o);
        end
        idle(1);
        checks++;
        if (bus.root_vld_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_drained: got %b expected 0", bus.root_vld_o);
        end
        // full FIFO with push and pop in the same cycle
        bus.root_rdy_i = 1'b0;
        drive_frame(36'h4);
        drive_frame(36'h5);
        for (int i = 0; i < 5; i++) begin
            drive_word(6'h00, 6'(i));
        end
        bus.root_rdy_i = 1'b1;
        drive_word(6'h06, 6'd5);
        checks++;
        if (bus.ovf_o !== 1'b0 || bus.drop_cnt_o !== 8'(exp_drop)) begin
            failures++;
            $display("[TB] FAIL pushpop_ovf: got ovf=%b drop=%0d expected ovf=0 drop=%0d", bus.ovf_o, bus.drop_cnt_o, exp_drop);
        end
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h5) begin
            failures++;
            $display("[TB] FAIL pushpop_head: got vld=%b root=%0h expected vld=1 root=5", bus.root_vld_o, bus.root_o);
        end
        idle(1);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h6) begin
            failures++;
            $display("[TB] FAIL pushpop_last: got vld=%b root=%0h expected vld=1 root=6", bus.root_vld_o, bus.root_o);
        end
        idle(1);
        checks++;
        if (bus.root_vld_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pushpop_drained: got %b expected 0", bus.root_vld_o);
        end
    endtask

    task automatic test_reset_mid_frame;
        bus.root_rdy_i = 1'b0;
        drive_frame(36'h9);
        drive_word(6'h01, 6'd0);
        drive_word(6'h02, 6'd1);
        drive_word(6'h03, 6'd2);
        rst = 1'b1;
        #1;
        exp_drop = 0;
        checks++;
        if (bus.root_vld_o !== 1'b0 || bus.root_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midrst_fifo: got vld=%b root=%0h expected vld=0 root=0", bus.root_vld_o, bus.root_o);
        end
        checks++;
        if (bus.drop_cnt_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL midrst_drop: got %0d expected 0", bus.drop_cnt_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.root_rdy_i = 1'b1;
        drive_frame(36'h0_420C_4146);
        checks++;
        if (bus.root_vld_o !== 1'b1 || bus.root_o !== 32'h420C_4146 || bus.range_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_root: got vld=%b root=%0h rerr=%b expected vld=1 root=420c4146 rerr=0", bus.root_vld_o, bus.root_o, bus.range_err_o);
        end
        checks++;
        if ({bus.frame_err_o, bus.tmo_err_o, bus.ovf_o} !== 3'b000 || bus.drop_cnt_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL midrst_clean: got pulses=%b drop=%0d expected pulses=000 drop=0", {bus.frame_err_o, bus.tmo_err_o, bus.ovf_o}, bus.drop_cnt_o);
        end
        idle(1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        checks         = 0;
        failures       = 0;
        exp_drop       = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        bus.sqrt_en    = 1'b0;
        bus.sqrt_t_wd  = '0;
        bus.sqrt_st    = '0;
        bus.root_rdy_i = 1'b1;

        test_reset();
        test_basic_root();
        test_range();
        test_frame_err();
        test_timeout();
        test_overflow();
        test_reset_mid_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
